// File: rtl/pl_round_sequencer_if.sv
// Round-sequencer control bundle: enable/ready/flush/done in, round pulse and job tokens out.
// Latency: wires only; timing is set entirely by pl_round_sequencer.
// Backpressure: none here; en and done_vec are how the datapath stalls the sequencer.
//   master: drives en, ready, flush, done_vec; observes the sequencer outputs
//   slave : the sequencer itself
interface pl_round_sequencer_if #(
  parameter int NUM_STAGES = 11,
  parameter int CTR_W      = 12
);
  logic                  en;
  logic                  ready;
  logic                  flush;
  logic [NUM_STAGES-1:0] done_vec;
  logic                  start_stage;
  logic [NUM_STAGES-1:0] stage_tok;
  logic                  valid;
  logic                  busy;
  logic [CTR_W-1:0]      round_ctr;
  logic                  timeout;

  modport master (
    output en, ready, flush, done_vec,
    input  start_stage, stage_tok, valid, busy, round_ctr, timeout
  );

  modport slave (
    input  en, ready, flush, done_vec,
    output start_stage, stage_tok, valid, busy, round_ctr, timeout
  );
endinterface

// File: rtl/pl_round_sequencer.sv
// Round controller for a NUM_STAGES pipeline: pulses start_stage every PERIOD cycles and shifts job tokens.
// Latency: all outputs registered; a job injected at a pulse raises valid NUM_STAGES advances later.
// Backpressure: en low freezes everything; with WAIT_DONE=1 a boundary waits for done from occupied stages.
//   Ports: clk, rst_n (async active-low), bus (slave modport: en, ready, flush, done_vec in;
//          start_stage, stage_tok, valid, busy, round_ctr, timeout out).
//   Parameter constraints: NUM_STAGES >= 2, 2**CTR_W > PERIOD.
module pl_round_sequencer #(
  parameter int NUM_STAGES = 11,
  parameter int PERIOD     = 2306,
  parameter int CTR_W      = 12,
  parameter int WAIT_DONE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pl_round_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  localparam logic [CTR_W-1:0] LAST = CTR_W'(PERIOD - 1);

  state_t                state;
  logic [NUM_STAGES-1:0] tok;
  logic                  valid_q;
  logic                  start_q;
  logic [CTR_W-1:0]      ctr;
  logic [CTR_W-1:0]      wait_ctr;
  logic                  timeout_q;

  logic                  ok;
  logic                  at_boundary;
  logic [NUM_STAGES-1:0] new_tok;

  // Only stages that actually hold a job gate the boundary; bubbles never block.
  assign ok          = (WAIT_DONE == 0) || ((bus.done_vec & tok) == tok);
  assign at_boundary = ((state == RUN) && (ctr == LAST)) || (state == WAIT);
  assign new_tok     = {tok[NUM_STAGES-2:0], bus.ready};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tok       <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      ctr       <= '0;
      wait_ctr  <= '0;
      timeout_q <= 1'b0;
    end else if (bus.flush) begin
      state     <= IDLE;
      tok       <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      ctr       <= '0;
      wait_ctr  <= '0;
      timeout_q <= 1'b0;
    end else if (!bus.en) begin
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ready) begin
            tok     <= NUM_STAGES'(1);
            start_q <= 1'b1;
            valid_q <= 1'b0;
            ctr     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (ctr != LAST) begin
            ctr <= ctr + CTR_W'(1);
          end else if (!ok) begin
            // round_ctr parks at LAST for the whole wait
            state    <= WAIT;
            wait_ctr <= '0;
          end
        end
        WAIT: begin
          if (wait_ctr != {CTR_W{1'b1}}) wait_ctr <= wait_ctr + CTR_W'(1);
          // Counter already at LAST here means this wait has spanned PERIOD edges.
          if (wait_ctr == LAST) timeout_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Shared advance for RUN boundaries and WAIT release; overrides the case above.
      if (at_boundary && ok) begin
        valid_q <= tok[NUM_STAGES-1];
        tok     <= new_tok;
        ctr     <= '0;
        if (|new_tok) begin
          start_q <= 1'b1;
          state   <= RUN;
        end else begin
          state   <= IDLE;
        end
      end
    end
  end

  assign bus.start_stage = start_q;
  assign bus.stage_tok   = tok;
  assign bus.valid       = valid_q;
  assign bus.busy        = (state != IDLE);
  assign bus.round_ctr   = ctr;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_pl_round_sequencer.sv
// Bench for pl_round_sequencer: table of {inputs, cycle count, expected outputs} on a
// fixed-period instance, plus hand sequences for async reset and done-wait/timeout.
module tb_pl_round_sequencer;
  localparam int NS = 3;
  localparam int P  = 8;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pl_round_sequencer_if #(.NUM_STAGES(NS), .CTR_W(CW)) ia ();
  pl_round_sequencer_if #(.NUM_STAGES(NS), .CTR_W(CW)) ib ();

  pl_round_sequencer #(.NUM_STAGES(NS), .PERIOD(P), .CTR_W(CW), .WAIT_DONE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  pl_round_sequencer #(.NUM_STAGES(NS), .PERIOD(P), .CTR_W(CW), .WAIT_DONE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          en;
    logic          ready;
    logic          flush;
    int            n;
    logic          st;
    logic [NS-1:0] tok;
    logic          vld;
    logic          bsy;
    logic [CW-1:0] ctr;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(logic e, logic r, logic f, int n,
                              logic st, logic [NS-1:0] tok, logic v, logic b, logic [CW-1:0] c);
    vec_t x;
    x.en = e; x.ready = r; x.flush = f; x.n = n;
    x.st = st; x.tok = tok; x.vld = v; x.bsy = b; x.ctr = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    // e r f  n   st tok    v  b  ctr
    vt[0]  = mk(1, 0, 0, 2, 0, 3'b000, 0, 0, 0);
    vt[1]  = mk(1, 1, 0, 1, 1, 3'b001, 0, 1, 0);  // start from IDLE
    vt[2]  = mk(1, 0, 0, 1, 0, 3'b001, 0, 1, 1);
    vt[3]  = mk(1, 0, 0, 6, 0, 3'b001, 0, 1, 7);
    vt[4]  = mk(1, 0, 0, 1, 1, 3'b010, 0, 1, 0);  // boundary, bubble in
    vt[5]  = mk(1, 0, 0, 8, 1, 3'b100, 0, 1, 0);
    vt[6]  = mk(1, 0, 0, 7, 0, 3'b100, 0, 1, 7);
    vt[7]  = mk(1, 0, 0, 1, 0, 3'b000, 1, 0, 0);  // job out, drained, no pulse
    vt[8]  = mk(1, 0, 0, 3, 0, 3'b000, 1, 0, 0);  // valid held in IDLE
    vt[9]  = mk(1, 1, 0, 1, 1, 3'b001, 0, 1, 0);  // continuous ready
    vt[10] = mk(1, 1, 0, 8, 1, 3'b011, 0, 1, 0);
    vt[11] = mk(1, 1, 0, 8, 1, 3'b111, 0, 1, 0);
    vt[12] = mk(1, 1, 0, 8, 1, 3'b111, 1, 1, 0);
    vt[13] = mk(1, 1, 0, 8, 1, 3'b111, 1, 1, 0);
    vt[14] = mk(1, 1, 0, 7, 0, 3'b111, 1, 1, 7);
    vt[15] = mk(1, 0, 0, 1, 1, 3'b110, 1, 1, 0);  // ready low at one boundary
    vt[16] = mk(1, 1, 0, 8, 1, 3'b101, 1, 1, 0);
    vt[17] = mk(1, 1, 0, 8, 1, 3'b011, 1, 1, 0);
    vt[18] = mk(1, 1, 0, 8, 1, 3'b111, 0, 1, 0);  // bubble leaves last stage
    vt[19] = mk(1, 1, 0, 8, 1, 3'b111, 1, 1, 0);
    vt[20] = mk(1, 1, 0, 3, 0, 3'b111, 1, 1, 3);
    vt[21] = mk(0, 1, 0, 5, 0, 3'b111, 1, 1, 3);  // en low: frozen
    vt[22] = mk(1, 1, 0, 4, 0, 3'b111, 1, 1, 7);
    vt[23] = mk(1, 1, 0, 1, 1, 3'b111, 1, 1, 0);  // pulse 13 cycles after previous
    vt[24] = mk(0, 1, 0, 1, 0, 3'b111, 1, 1, 0);  // en low kills the pulse
    vt[25] = mk(1, 1, 0, 7, 0, 3'b111, 1, 1, 7);
    vt[26] = mk(1, 1, 1, 1, 0, 3'b000, 0, 0, 0);  // flush on boundary edge
    vt[27] = mk(1, 0, 0, 2, 0, 3'b000, 0, 0, 0);

    ia.en = 1'b0; ia.ready = 1'b0; ia.flush = 1'b0; ia.done_vec = 3'b111;
    ib.en = 1'b0; ib.ready = 1'b0; ib.flush = 1'b0; ib.done_vec = 3'b111;

    // Reset state
    #12;
    check("rst_start", ia.start_stage, 0);
    check("rst_tok",   ia.stage_tok, 0);
    check("rst_valid", ia.valid, 0);
    check("rst_busy",  ia.busy, 0);
    check("rst_ctr",   ia.round_ctr, 0);
    check("rst_tmo",   ia.timeout, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // Table-driven run on the fixed-period instance
    for (int i = 0; i < 28; i++) begin
      ia.en    = vt[i].en;
      ia.ready = vt[i].ready;
      ia.flush = vt[i].flush;
      step(vt[i].n);
      check($sformatf("v%0d_start", i), ia.start_stage, vt[i].st);
      check($sformatf("v%0d_tok", i),   ia.stage_tok,   vt[i].tok);
      check($sformatf("v%0d_valid", i), ia.valid,       vt[i].vld);
      check($sformatf("v%0d_busy", i),  ia.busy,        vt[i].bsy);
      check($sformatf("v%0d_ctr", i),   ia.round_ctr,   vt[i].ctr);
      check($sformatf("v%0d_tmo", i),   ia.timeout,     0);
    end
    ia.flush = 1'b0;

    // Async reset mid-round with two tokens
    ia.en = 1'b1; ia.ready = 1'b1;
    step(1);
    step(8);
    step(3);
    check("ar_pre_tok", ia.stage_tok, 3'b011);
    check("ar_pre_ctr", ia.round_ctr, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_start", ia.start_stage, 0);
    check("ar_tok",   ia.stage_tok, 0);
    check("ar_valid", ia.valid, 0);
    check("ar_busy",  ia.busy, 0);
    check("ar_ctr",   ia.round_ctr, 0);
    #10 rst_n = 1'b1;
    ia.ready = 1'b0;
    step(3);
    check("ar_idle_busy", ia.busy, 0);
    check("ar_idle_tok",  ia.stage_tok, 0);
    ia.ready = 1'b1;
    step(1);
    check("ar_restart_start", ia.start_stage, 1);
    check("ar_restart_tok",   ia.stage_tok, 3'b001);
    ia.ready = 1'b0; ia.flush = 1'b1;
    step(1);
    ia.flush = 1'b0;
    check("ar_flush_busy", ia.busy, 0);

    // Done-wait instance: short stall
    ib.en = 1'b1; ib.ready = 1'b1; ib.done_vec = 3'b111;
    step(1);
    check("w_start0", ib.start_stage, 1);
    check("w_tok0",   ib.stage_tok, 3'b001);
    ib.ready = 1'b0;
    step(7);
    check("w_ctr7", ib.round_ctr, 7);
    ib.done_vec = 3'b110;            // occupied stage 0 not done
    step(1);
    check("w_hold_start", ib.start_stage, 0);
    check("w_hold_ctr",   ib.round_ctr, 7);
    check("w_hold_busy",  ib.busy, 1);
    step(2);
    ib.done_vec = 3'b111;
    step(1);                         // released 3 cycles late
    check("w_rel_start", ib.start_stage, 1);
    check("w_rel_tok",   ib.stage_tok, 3'b010);
    check("w_rel_ctr",   ib.round_ctr, 0);
    check("w_rel_tmo",   ib.timeout, 0);

    // Long stall reaching timeout
    step(7);
    ib.done_vec = 3'b101;            // occupied stage 1 not done
    step(8);
    check("t_wait_start", ib.start_stage, 0);
    check("t_wait_tok",   ib.stage_tok, 3'b010);
    check("t_wait_tmo",   ib.timeout, 0);
    ib.done_vec = 3'b111;
    step(1);
    check("t_rel_start", ib.start_stage, 1);
    check("t_rel_tok",   ib.stage_tok, 3'b100);
    check("t_rel_tmo",   ib.timeout, 1);

    // Unoccupied stages not done must not stall; timeout stays sticky
    ib.done_vec = 3'b100;
    step(8);
    check("t_drain_busy",  ib.busy, 0);
    check("t_drain_valid", ib.valid, 1);
    check("t_drain_tok",   ib.stage_tok, 0);
    check("t_drain_start", ib.start_stage, 0);
    check("t_sticky_tmo",  ib.timeout, 1);
    ib.flush = 1'b1;
    step(1);
    ib.flush = 1'b0;
    check("t_flush_tmo",   ib.timeout, 0);
    check("t_flush_valid", ib.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pl_round_sequencer.md
# pl_round_sequencer

Round-based controller for the pipelined encrypter datapath, generalised in stage count, round period and advance mode. Every `PERIOD` cycles it pulses `start_stage` to all pipeline stages and tracks which stages hold a job in a token shift register. It also flags the job leaving the last stage on `valid` and drains back to idle when no work remains. In done-wait mode a round boundary is held until every occupied stage reports done, and an over-long wait is reported on a sticky `timeout`.

## Interface
- `NUM_STAGES`, 11, number of pipeline stages (token register width), ≥2
- `PERIOD`, 2306, cycles per round; round counter runs 0..PERIOD-1
- `CTR_W`, 12, width of round and wait counters; must satisfy 2^CTR_W > PERIOD
- `WAIT_DONE`, 0, 0 = fixed-period advance; 1 = advance also requires done from occupied stages

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  global enable; low freezes counters and FSM, forces `start_stage` low
- `ready`  in  1  new job available; sampled at a round boundary, or in IDLE
- `flush`  in  1  synchronous abort: clears tokens, `valid`, counters, returns to IDLE
- `done_vec`  in  NUM_STAGES  per-stage done level, bit i = stage i finished current round
- `start_stage`  out  1  one-cycle pulse at first cycle of each round
- `stage_tok`  out  NUM_STAGES  bit i = stage i holds a job this round
- `valid`  out  1  job has left the last stage; output RAMs hold a result
- `busy`  out  1  FSM not in IDLE
- `round_ctr`  out  CTR_W  current cycle within round
- `timeout`  out  1  sticky: a WAIT lasted ≥ PERIOD cycles

## Operation
- States: IDLE, RUN, WAIT. Reset: IDLE, all outputs and counters 0.
- IDLE, on edge with `en && ready`:
  - `stage_tok` ← 1.
  - `start_stage` ← 1.
  - `valid` ← 0.
  - `round_ctr` ← 0.
  - Go to RUN.
  - Otherwise hold; `valid` keeps its last value.
- RUN with `en`: `round_ctr` increments. At `round_ctr == PERIOD-1` the boundary check is made on that edge:
  - `ok` = (WAIT_DONE==0) or ((`done_vec` & `stage_tok`) == `stage_tok`).
  - If ok, advance:
    - `valid` ← `stage_tok[NUM_STAGES-1]`.
    - `stage_tok` ← {`stage_tok[NUM_STAGES-2:0]`, `ready`}.
    - `round_ctr` ← 0.
  - After the advance:
    - If the new `stage_tok` is non-zero: `start_stage` ← 1, stay in RUN.
    - If it is zero: no pulse, go to IDLE (drain complete).
  - If not ok: go to WAIT; `round_ctr` holds PERIOD-1; wait counter ← 0.
- WAIT with `en`:
  - The wait counter increments, saturating at all-ones.
  - The `ok` check is repeated every cycle; on ok, perform the advance above.
  - `timeout` ← 1 when the wait counter reaches PERIOD-1; it is cleared only by reset or `flush`.
- `en` low in any state: all registers hold, `start_stage` = 0, no boundary check, `ready` ignored.
- `flush` has priority over everything except reset; it takes effect on the next edge regardless of `en`:
  - Clears `stage_tok`, `valid`, `timeout`, `round_ctr`, wait counter and `start_stage`.
  - Goes to IDLE.
- `ready` sampled low at a boundary inserts a bubble (0 token). Bubbles propagate, and `valid` goes low when a bubble leaves the last stage.

## Timing
- All outputs registered; `round_ctr`, `stage_tok` and `valid` update on the same edge that raises `start_stage`.
- Round period: exactly PERIOD cycles between `start_stage` pulses in RUN with `en` high and, if WAIT_DONE, `ok` true at the boundary.
- Each cycle `en` is low lengthens the current round by one cycle; each WAIT cycle does the same.
- Job latency: a job injected with pulse k makes `valid` rise with the edge of advance k+NUM_STAGES, i.e. NUM_STAGES·PERIOD cycles after its first `start_stage`, with no stalls.
- Async reset mid-operation: outputs go to 0 immediately. The first start needs `ready` sampled after `rst_n` deasserts.

## Test plan
- Single job (NUM_STAGES=3, PERIOD=8): `ready` high for one cycle, sampled in IDLE at edge t -> `start_stage` pulses at t+1, t+9, t+17; at t+25 `valid`=1, `stage_tok`=0, `busy`=0, no pulse.
- Continuous `ready` -> pulses every 8 cycles; `stage_tok` 001, 011, 111; `valid` rises on the 4th advance and stays high; dropping `ready` for one boundary gives one `valid`-low round 3 rounds later.
- `en` low for 5 cycles at `round_ctr`=3 -> counter frozen at 3, next pulse 13 cycles after the previous one, no pulse while `en` low.
- WAIT_DONE=1, `done_vec` of an occupied stage held low 3 cycles past boundary -> pulse delayed 3 cycles, `timeout`=0. Held low for 8 -> `timeout`=1 and stays set after the advance.
- `flush` asserted coincident with a boundary edge -> no pulse; next cycle `stage_tok`=0, `valid`=0, `busy`=0, `round_ctr`=0.
- `rst_n` pulsed low mid-round with 2 tokens -> all outputs 0 asynchronously; after release, idle until `ready`.
